// File: rtl/vram_arb_pkg.sv
// Shared types for the VRAM arbiter:
// requester source tags and issue FSM states.
package vram_arb_pkg;

  typedef enum logic {
    SRC_DISP = 1'b0,
    SRC_REND = 1'b1
  } src_e;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

endpackage

// File: rtl/vram_tag_fifo.sv
// Synchronous FIFO of 1-bit source tags,
// one entry per master read still awaiting data.
module vram_tag_fifo #(
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          tag_in,
  input  logic          pop,
  output logic          tag_out,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the head slot, so a push into a full FIFO is legal then.
  assign do_push = push && (!full || do_pop);
  assign tag_out = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= tag_in;
  end

endmodule

// File: rtl/vram_arbiter.sv
// Two-requester SDRAM arbiter: display scanout vs render,
// pipelined Avalon-MM master with in-order read return routing.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W     = 25,
  parameter int DATA_W     = 16,
  parameter int MAX_PEND   = 8,
  parameter int STARVE_LIM = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   d_address,
  input  logic                d_read,
  output logic                d_waitrequest,
  output logic [DATA_W-1:0]   d_readdata,
  output logic                d_readdatavalid,
  input  logic [ADDR_W-1:0]   r_address,
  input  logic                r_read,
  input  logic                r_write,
  input  logic [DATA_W-1:0]   r_writedata,
  input  logic [DATA_W/8-1:0] r_byteenable,
  output logic                r_waitrequest,
  output logic [DATA_W-1:0]   r_readdata,
  output logic                r_readdatavalid,
  output logic [ADDR_W-1:0]   m_address,
  output logic                m_read,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_writedata,
  output logic [DATA_W/8-1:0] m_byteenable,
  input  logic                m_waitrequest,
  input  logic [DATA_W-1:0]   m_readdata,
  input  logic                m_readdatavalid
);

  localparam int CW = $clog2(MAX_PEND + 1);
  localparam int SW = $clog2(STARVE_LIM + 1);

  state_e        state;
  src_e          src;
  logic [CW-1:0] count;
  logic [CW:0]   used;
  logic [SW-1:0] starve;
  logic          full;
  logic          empty;
  logic          tag;
  logic          can_accept;
  logic          read_ok;
  logic          r_req;
  logic          d_ok;
  logic          r_ok;
  logic          starved;
  logic          grant_d;
  logic          grant_r;
  logic          push;
  logic          tag_hit;

  // The read on the bus still needs a tag slot even if not yet accepted.
  assign used       = {1'b0, count} + {{CW{1'b0}}, m_read};
  assign read_ok    = !full && (used < (CW+1)'(MAX_PEND));
  assign can_accept = !reset && (state == IDLE || !m_waitrequest);

  assign r_req   = r_read || r_write;
  assign d_ok    = d_read && read_ok;
  assign r_ok    = r_write || (r_read && read_ok);
  assign starved = (starve == SW'(STARVE_LIM));
  assign grant_r = can_accept && r_ok && (!d_ok || starved);
  assign grant_d = can_accept && d_ok && !grant_r;

  assign d_waitrequest = !grant_d;
  assign r_waitrequest = !grant_r;

  assign push    = m_read && !m_waitrequest;
  assign tag_hit = m_readdatavalid && !empty;

  assign d_readdata      = m_readdata;
  assign r_readdata      = m_readdata;
  assign d_readdatavalid = tag_hit && (src_e'(tag) == SRC_DISP);
  assign r_readdatavalid = tag_hit && (src_e'(tag) == SRC_REND);

  vram_tag_fifo #(
    .DEPTH(MAX_PEND)
  ) u_tags (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .tag_in (src),
    .pop    (m_readdatavalid),
    .tag_out(tag),
    .full   (full),
    .empty  (empty),
    .count  (count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve <= '0;
    end else if (grant_r) begin
      starve <= '0;
    end else if (r_req && !starved) begin
      starve <= starve + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      src          <= SRC_DISP;
      m_read       <= 1'b0;
      m_write      <= 1'b0;
      m_address    <= '0;
      m_writedata  <= '0;
      m_byteenable <= '0;
    end else if (can_accept) begin
      unique case (1'b1)
        grant_r: begin
          state        <= ISSUE;
          src          <= SRC_REND;
          m_read       <= !r_write;
          m_write      <= r_write;
          m_address    <= r_address;
          m_writedata  <= r_writedata;
          m_byteenable <= r_byteenable;
        end
        grant_d: begin
          state        <= ISSUE;
          src          <= SRC_DISP;
          m_read       <= 1'b1;
          m_write      <= 1'b0;
          m_address    <= d_address;
          m_writedata  <= '0;
          m_byteenable <= '1;
        end
        default: begin
          state   <= IDLE;
          m_read  <= 1'b0;
          m_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a read-return
// scoreboard and immediate-assertion checks.
module tb_vram_arbiter;
  import vram_arb_pkg::*;

  localparam int AW = 25;
  localparam int DW = 16;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] d_address;
  logic          d_read;
  logic          d_waitrequest;
  logic [DW-1:0] d_readdata;
  logic          d_readdatavalid;
  logic [AW-1:0] r_address;
  logic          r_read;
  logic          r_write;
  logic [DW-1:0] r_writedata;
  logic [BW-1:0] r_byteenable;
  logic          r_waitrequest;
  logic [DW-1:0] r_readdata;
  logic          r_readdatavalid;
  logic [AW-1:0] m_address;
  logic          m_read;
  logic          m_write;
  logic [DW-1:0] m_writedata;
  logic [BW-1:0] m_byteenable;
  logic          m_waitrequest;
  logic [DW-1:0] m_readdata;
  logic          m_readdatavalid;

  typedef struct {
    logic          src;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   rg = 0;

  always #5 clk = ~clk;

  vram_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .d_address      (d_address),
    .d_read         (d_read),
    .d_waitrequest  (d_waitrequest),
    .d_readdata     (d_readdata),
    .d_readdatavalid(d_readdatavalid),
    .r_address      (r_address),
    .r_read         (r_read),
    .r_write        (r_write),
    .r_writedata    (r_writedata),
    .r_byteenable   (r_byteenable),
    .r_waitrequest  (r_waitrequest),
    .r_readdata     (r_readdata),
    .r_readdatavalid(r_readdatavalid),
    .m_address      (m_address),
    .m_read         (m_read),
    .m_write        (m_write),
    .m_writedata    (m_writedata),
    .m_byteenable   (m_byteenable),
    .m_waitrequest  (m_waitrequest),
    .m_readdata     (m_readdata),
    .m_readdatavalid(m_readdatavalid)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push_exp(input logic s, input logic [DW-1:0] d);
    exp_t e;
    e.src  = s;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic ret_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL %s scoreboard underflow observed=0 expected=1", tag);
      return;
    end
    e = sb.pop_front();
    m_readdatavalid = 1'b1;
    m_readdata      = e.data;
    settle();
    chk({tag, " dval"}, d_readdatavalid, e.src == SRC_DISP);
    chk({tag, " rval"}, r_readdatavalid, e.src == SRC_REND);
    chk({tag, " data"},
        (e.src == SRC_DISP) ? d_readdata : r_readdata, e.data);
    tick();
    m_readdatavalid = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, " m_read"}, m_read, 0);
    chk({tag, " m_write"}, m_write, 0);
    chk({tag, " m_addr"}, m_address, 0);
    chk({tag, " m_wdata"}, m_writedata, 0);
    chk({tag, " m_be"}, m_byteenable, 0);
    chk({tag, " d_wait"}, d_waitrequest, 1);
    chk({tag, " r_wait"}, r_waitrequest, 1);
    chk({tag, " d_val"}, d_readdatavalid, 0);
    chk({tag, " r_val"}, r_readdatavalid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    d_address       = '0;
    d_read          = 1'b0;
    r_address       = '0;
    r_read          = 1'b0;
    r_write         = 1'b0;
    r_writedata     = '0;
    r_byteenable    = '0;
    m_waitrequest   = 1'b0;
    m_readdata      = '0;
    m_readdatavalid = 1'b0;

    // reset state, with requests and a stray return present
    reset = 1'b1;
    d_read = 1'b1;
    r_write = 1'b1;
    m_readdatavalid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_checks("rst");
    d_read = 1'b0;
    r_write = 1'b0;
    m_readdatavalid = 1'b0;
    reset = 1'b0;
    tick();
    settle();
    chk("idle d_wait", d_waitrequest, 1);

    // single display read
    d_read = 1'b1;
    d_address = 25'h100;
    settle();
    chk("t1 grant", d_waitrequest, 0);
    chk("t1 m_read early", m_read, 0);
    tick();
    d_read = 1'b0;
    push_exp(SRC_DISP, 16'hBEEF);
    settle();
    chk("t1 m_read", m_read, 1);
    chk("t1 m_addr", m_address, 25'h100);
    tick();
    chk("t1 back idle", m_read, 0);
    ret_check("t1 ret");

    // return with nothing outstanding is dropped
    m_readdatavalid = 1'b1;
    m_readdata = 16'h5555;
    settle();
    chk("empty d_val", d_readdatavalid, 0);
    chk("empty r_val", r_readdatavalid, 0);
    chk("passthru d", d_readdata, 16'h5555);
    chk("passthru r", r_readdata, 16'h5555);
    tick();
    m_readdatavalid = 1'b0;

    // interleaved D,R,D reads
    d_read = 1'b1;
    d_address = 25'h200;
    settle();
    chk("t2 d0 grant", d_waitrequest, 0);
    push_exp(SRC_DISP, 16'h1111);
    tick();
    d_read = 1'b0;
    r_read = 1'b1;
    r_address = 25'h300;
    settle();
    chk("t2 r grant", r_waitrequest, 0);
    chk("t2 addr0", m_address, 25'h200);
    push_exp(SRC_REND, 16'h2222);
    tick();
    r_read = 1'b0;
    d_read = 1'b1;
    d_address = 25'h204;
    settle();
    chk("t2 d1 grant", d_waitrequest, 0);
    chk("t2 addr1", m_address, 25'h300);
    push_exp(SRC_DISP, 16'h3333);
    tick();
    d_read = 1'b0;
    settle();
    chk("t2 addr2", m_address, 25'h204);
    chk("t2 m_read", m_read, 1);
    tick();
    repeat (3) ret_check("t2 ret");

    // render write held off by m_waitrequest; write beats read
    r_write = 1'b1;
    r_read = 1'b1;
    r_address = 25'h2A;
    r_writedata = 16'h1234;
    r_byteenable = 2'b11;
    m_waitrequest = 1'b1;
    settle();
    chk("t3 grant", r_waitrequest, 0);
    tick();
    r_address = 25'h55;
    r_writedata = 16'hFFFF;
    r_byteenable = 2'b01;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("t3 m_write", m_write, 1);
      chk("t3 m_read", m_read, 0);
      chk("t3 m_addr", m_address, 25'h2A);
      chk("t3 m_wdata", m_writedata, 16'h1234);
      chk("t3 m_be", m_byteenable, 2'b11);
      chk("t3 r_wait", r_waitrequest, 1);
      tick();
    end
    r_write = 1'b0;
    r_read = 1'b0;
    m_waitrequest = 1'b0;
    settle();
    chk("t3 accept", m_write, 1);
    tick();
    chk("t3 done", m_write, 0);

    // starvation: a lone render grant clears the counter first
    r_write = 1'b1;
    r_address = 25'h10;
    settle();
    chk("t4 pre grant", r_waitrequest, 0);
    tick();
    r_write = 1'b0;
    for (int i = 0; i < 36; i++) begin
      exp_t e;
      logic exp_r;
      d_read = (i < 34);
      r_read = (i < 34);
      d_address = AW'(32'h1000 + i);
      r_address = AW'(32'h2000 + i);
      m_readdatavalid = 1'b0;
      if (i >= 2 && sb.size() > 0) begin
        e = sb.pop_front();
        m_readdatavalid = 1'b1;
        m_readdata = e.data;
      end
      settle();
      if (i >= 2) begin
        chk("t4 d_val", d_readdatavalid, e.src == SRC_DISP);
        chk("t4 r_val", r_readdatavalid, e.src == SRC_REND);
        chk("t4 data", d_readdata, e.data);
      end
      if (i < 34) begin
        exp_r = ((i % 17) == 16);
        chk("t4 r_wait", r_waitrequest, !exp_r);
        chk("t4 d_wait", d_waitrequest, exp_r);
        if (!r_waitrequest) rg++;
        push_exp(exp_r ? SRC_REND : SRC_DISP, DW'(32'hC000 + i));
      end
      tick();
    end
    m_readdatavalid = 1'b0;
    chk("t4 render grants", rg, 2);
    chk("t4 sb drained", sb.size(), 0);

    // tag FIFO full: 8 reads issue, the 9th waits
    d_read = 1'b1;
    d_address = 25'h3000;
    for (int i = 0; i < 12; i++) begin
      settle();
      chk("t5 d_wait", d_waitrequest, i >= 8);
      if (i < 8) push_exp(SRC_DISP, DW'(32'hA000 + i));
      tick();
    end
    r_write = 1'b1;
    r_address = 25'h77;
    settle();
    chk("t5 write ok", r_waitrequest, 0);
    chk("t5 d still held", d_waitrequest, 1);
    tick();
    r_write = 1'b0;
    settle();
    chk("t5 m_write", m_write, 1);
    chk("t5 d held", d_waitrequest, 1);
    tick();
    ret_check("t5 ret0");
    settle();
    chk("t5 ninth grant", d_waitrequest, 0);
    push_exp(SRC_DISP, 16'hA008);
    tick();
    d_read = 1'b0;
    repeat (8) ret_check("t5 drain");

    // reset with three reads in flight
    d_read = 1'b1;
    d_address = 25'h400;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t6 grant", d_waitrequest, 0);
      tick();
    end
    d_read = 1'b0;
    settle();
    chk("t6 in flight", m_read, 1);
    reset = 1'b1;
    settle();
    reset_checks("t6 rst");
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_readdatavalid = 1'b1;
      m_readdata = DW'(32'hD000 + i);
      settle();
      chk("t6 late d_val", d_readdatavalid, 0);
      chk("t6 late r_val", r_readdatavalid, 0);
      tick();
    end
    m_readdatavalid = 1'b0;

    // recovery after reset
    r_read = 1'b1;
    r_address = 25'h500;
    settle();
    chk("t7 grant", r_waitrequest, 0);
    push_exp(SRC_REND, 16'h7E57);
    tick();
    r_read = 1'b0;
    settle();
    chk("t7 m_addr", m_address, 25'h500);
    tick();
    ret_check("t7 ret");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
